// File: rtl/req_ack_responder.sv
// Downstream req/ack responder: one single-cycle ack per accepted req rise, after LATENCY edges.
// Optional 16-bit ack counter port enabled by defining REQ_ACK_RESP_CNT_EN.
module req_ack_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    output logic        o_ack,
    output logic        o_busy,
    output logic        o_overflow
`ifdef REQ_ACK_RESP_CNT_EN
    ,
    output logic [15:0] o_ack_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [PW-1:0] P_FULL = PW'(DEPTH);
    localparam logic [TW-1:0] T_LOAD = TW'(LATENCY - 1);

    logic          r_req_q;
    logic [PW-1:0] r_pending;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic          r_ack;
    logic          r_busy;
    logic          r_overflow;

    logic          w_rise;
    logic          w_done;
    logic          w_full;
    logic          w_accept;
    logic          w_drop;
    logic          w_start;
    logic [PW-1:0] w_pending_nxt;
    logic [1:0]    w_state_nxt;
    logic [TW-1:0] w_timer_nxt;

    assign w_rise   = i_req & ~r_req_q;
    assign w_done   = (r_state == S_ACK);
    assign w_full   = (r_pending == P_FULL);
    // A completion on the same edge frees a slot, so a rise is never dropped then.
    assign w_accept = w_rise & (~w_full | w_done);
    assign w_drop   = w_rise & w_full & ~w_done;

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_accept && !w_done) begin
            w_pending_nxt = r_pending + PW'(1);
        end else if (!w_accept && w_done) begin
            w_pending_nxt = r_pending - PW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_start = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_timer == TW'(1)) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            S_ACK: begin
                if (w_pending_nxt != '0) begin
                    w_start = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Service start is shared by IDLE and ACK; LATENCY of 1 skips WAIT entirely.
        if (w_start) begin
            w_timer_nxt = T_LOAD;
            w_state_nxt = (LATENCY == 1) ? S_ACK : S_WAIT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_q    <= 1'b0;
            r_pending  <= '0;
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_req_q    <= i_req;
            r_pending  <= w_pending_nxt;
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_ack      <= (w_state_nxt == S_ACK);
            r_busy     <= (w_pending_nxt != '0);
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign o_ack      = r_ack;
    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

`ifdef REQ_ACK_RESP_CNT_EN
    logic [15:0] r_ack_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack_cnt <= '0;
        end else if (r_ack) begin
            r_ack_cnt <= r_ack_cnt + 16'd1;
        end
    end

    assign o_ack_cnt = r_ack_cnt;
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed-vector bench for req_ack_responder; four instances cover different LATENCY/DEPTH.
// Bit k of each vector is the req driven into, or output expected at, edge k after reset release.
module tb_req_ack_responder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [3:0]  busy;
    logic [3:0]  ovf;
`ifdef REQ_ACK_RESP_CNT_EN
    logic [15:0] cnt [4];
`endif

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    req_ack_responder #(.LATENCY(3), .DEPTH(4)) u_l3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]),
        .o_ack(ack[0]), .o_busy(busy[0]), .o_overflow(ovf[0])
`ifdef REQ_ACK_RESP_CNT_EN
        , .o_ack_cnt(cnt[0])
`endif
    );

    req_ack_responder #(.LATENCY(2), .DEPTH(4)) u_l2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]),
        .o_ack(ack[1]), .o_busy(busy[1]), .o_overflow(ovf[1])
`ifdef REQ_ACK_RESP_CNT_EN
        , .o_ack_cnt(cnt[1])
`endif
    );

    req_ack_responder #(.LATENCY(1), .DEPTH(4)) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[2]),
        .o_ack(ack[2]), .o_busy(busy[2]), .o_overflow(ovf[2])
`ifdef REQ_ACK_RESP_CNT_EN
        , .o_ack_cnt(cnt[2])
`endif
    );

    req_ack_responder #(.LATENCY(5), .DEPTH(2)) u_l5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[3]),
        .o_ack(ack[3]), .o_busy(busy[3]), .o_overflow(ovf[3])
`ifdef REQ_ACK_RESP_CNT_EN
        , .o_ack_cnt(cnt[3])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are observed 1 time unit after edge k-1, i.e. the value edge k samples.
    task automatic run_vec(input int u, input bit do_rst, input logic [31:0] rq,
                           input logic [31:0] ak, input logic [31:0] bs,
                           input logic [31:0] ov, input int n, input string name);
        if (do_rst) begin
            rst_n  = 1'b0;
            req[u] = 1'b0;
            @(posedge clk);
            #1;
            check({name, " rst ack"}, {31'd0, ack[u]}, 32'd0);
            check({name, " rst busy"}, {31'd0, busy[u]}, 32'd0);
            check({name, " rst ovf"}, {31'd0, ovf[u]}, 32'd0);
            rst_n = 1'b1;
        end
        for (int k = 1; k <= n; k++) begin
            req[u] = rq[k];
            check($sformatf("%s ack k=%0d", name, k), {31'd0, ack[u]}, {31'd0, ak[k]});
            check($sformatf("%s busy k=%0d", name, k), {31'd0, busy[u]}, {31'd0, bs[k]});
            check($sformatf("%s ovf k=%0d", name, k), {31'd0, ovf[u]}, {31'd0, ov[k]});
            @(posedge clk);
            #1;
        end
        req[u] = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        #2;

        // LATENCY=3: rise at edge 1 -> ack at edge 4, busy across edges 2..4
        run_vec(0, 1'b1, 32'h0000_0002, 32'h0000_0010, 32'h0000_001C, 32'h0, 7, "single");

        // LATENCY=2: rises at 1 and 8 -> acks at 3 and 10
        run_vec(1, 1'b1, 32'h0000_0102, 32'h0000_0408, 32'h0000_060C, 32'h0, 12, "spaced");

        // LATENCY=1: rises at 1,3,5 -> acks at 2,4,6
        run_vec(2, 1'b1, 32'h0000_002A, 32'h0000_0054, 32'h0000_0054, 32'h0, 8, "lat1");

        // LATENCY=5 DEPTH=2: third rise dropped, overflow sticky from edge 5
        run_vec(3, 1'b1, 32'h0000_002A, 32'h0000_0840, 32'h0000_0FFC, 32'h0000_7FC0, 14, "ovf");

        // Rise on the ack edge while full is accepted: acks at 6, 11, 16
        run_vec(3, 1'b1, 32'h0000_004A, 32'h0001_0840, 32'h0001_FFFC, 32'h0, 18, "ackfull");

        // Reset mid-operation: pending=2 in WAIT, async reset mid-cycle
        run_vec(3, 1'b1, 32'h0000_000A, 32'h0, 32'h0000_001C, 32'h0, 4, "midpre");
        #3;
        rst_n  = 1'b0;
        req[3] = 1'b1;
        #1;
        check("async ack", {31'd0, ack[3]}, 32'd0);
        check("async busy", {31'd0, busy[3]}, 32'd0);
        check("async ovf", {31'd0, ovf[3]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // req held high through release: only the fresh rise is acked, at edge 1+5
        run_vec(3, 1'b0, 32'h0000_1FFE, 32'h0000_0040, 32'h0000_007C, 32'h0, 12, "midpost");

`ifdef REQ_ACK_RESP_CNT_EN
        run_vec(2, 1'b1, 32'h0000_02AA, 32'h0000_0554, 32'h0000_0554, 32'h0, 11, "cnt5");
        check("cnt five", {16'd0, cnt[2]}, 32'd5);
        force u_l1.r_ack_cnt = 16'hFFFF;
        #1;
        release u_l1.r_ack_cnt;
        check("cnt preload", {16'd0, cnt[2]}, 32'h0000_FFFF);
        run_vec(2, 1'b0, 32'h0000_0002, 32'h0000_0004, 32'h0000_0004, 32'h0, 3, "cntwrap");
        check("cnt wrap", {16'd0, cnt[2]}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Handshake responder on the downstream side of the req/ack interface. Detects each rising edge of `req`, queues it, and returns exactly one single-cycle `ack` pulse per accepted request after a fixed, parameterised latency. It serves as the reference target for the team's req/ack SVA checks: each `$rose(req)` is eventually answered by `ack` (`##[1:$]`), in order, with no ack for dropped requests.

## Interface
- `LATENCY`, 2, clock edges from sampling a req rise to sampling `ack` high; legal range 1..255.
- `DEPTH`, 4, maximum outstanding requests, including the one in service; legal range 1..15.
- `clk`  input  1  clock; all sampling on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  1  request level from upstream; only rising edges are significant.
- `ack`  output  1  registered single-cycle acknowledge pulse; one pulse per accepted request.
- `busy`  output  1  registered; 1 while any request is outstanding (pending != 0).
- `overflow`  output  1  sticky; set when a req rise is dropped because the queue is full.

## Operation
- **Edge detect.** `req_q` is `req` registered, reset value 0. `req_rise = req & ~req_q`. A `req` already high at the first edge after reset counts as a rise.
- **Pending counter.** Width `$clog2(DEPTH+1)`, range 0..DEPTH.
  - +1 on an accepted rise.
  - −1 at the edge that samples `ack` high.
  - Both on the same edge: net 0, and the rise is always accepted.
- **Full.** If pending == DEPTH and a rise arrives with no completion on that edge:
  - the rise is dropped and pending is unchanged;
  - `overflow` is set and stays 1 until reset;
  - no ack is ever generated for the dropped rise.
- **FSM states.** IDLE, WAIT, ACK, with a timer of width `$clog2(LATENCY+1)`.
  - **Service start** (shared by IDLE and ACK): load timer = LATENCY−1 and go to WAIT. If LATENCY == 1, go directly to ACK instead.
  - **IDLE:** on an accepted rise, do service start; otherwise stay in IDLE.
  - **WAIT:** if timer == 1, go to ACK; otherwise decrement the timer.
  - **ACK:** `ack` = 1 for exactly this cycle. On the next edge the completion is counted. If pending after the update is > 0 (including a rise on that same edge), do service start; otherwise go to IDLE.
- **Ordering.** Requests are served strictly in arrival order. `ack` never asserts while pending == 0.
- **No level coupling.** `req` falling, or held high, has no effect.

## Timing
- **Reset values.** Asynchronous assert drives all of the following immediately: `ack` = 0, `busy` = 0, `overflow` = 0, state = IDLE, pending = 0, timer = 0, `req_q` = 0.
- **Reset mid-operation.** All outstanding requests are discarded; no ack is emitted for them after release.
- **First request.** Rise sampled at edge E with nothing pending → `ack` sampled high at edge E+LATENCY only.
- **Back-to-back.** A queued request's ack is sampled at (previous ack edge)+LATENCY. With LATENCY == 1, `ack` stays high on consecutive cycles, one cycle per request.
- **`busy` timing.**
  - Rises on the edge after the accepted rise.
  - Falls on the edge that completes the last ack.

## Configuration
- **`REQ_ACK_RESP_CNT_EN` defined:** adds output port `ack_cnt  output  16`.
  - Counts ack pulses; increments at each edge that samples `ack` high.
  - Wraps 0xFFFF→0; reset value 0.
- **`REQ_ACK_RESP_CNT_EN` undefined:** `ack_cnt` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Single request.** LATENCY=3; `req` high for one cycle, sampled at the edge at t=15 → `ack` high only at the edge at t=45; `busy` high from t=15+ through t=45; `overflow` stays 0.
- **Two spaced requests.** LATENCY=2; rises at edges 1 and 8 → acks at edges 3 and 10, each one cycle wide; a `first_match(##[1:$] ack)` checker passes twice.
- **Back-to-back with LATENCY=1.** LATENCY=1, DEPTH=4; three rises at edges 1, 3 and 5 (req toggled) → `ack` high at edges 2, 4 and 6.
- **Overflow and simultaneous events.** LATENCY=5, DEPTH=2; rises at edges 1, 3 and 5 → acks at edges 6 and 11 only; `overflow` = 1 from edge 5 onward.
  - Separately, a rise coinciding with an ack edge while full is accepted.
- **Reset mid-operation.** Assert `rst_n`=0 asynchronously while in WAIT with pending=2 → `ack`, `busy` and `overflow` are 0 immediately; no ack after release; `req` held high through release → ack at (first edge)+LATENCY.
- **Macro enabled.** With `REQ_ACK_RESP_CNT_EN`, 5 requests → `ack_cnt` = 5; preload test forcing 65535 → wraps to 0 on the next ack.
